// File: rtl/id_pipe.sv
// Registered instruction-decode stage: decodes a MIPS32 logic/shift subset, forwards
// operands from EX/MEM, stalls on load-use hazards and presents results over valid/ready.
module id_pipe #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [31:0]       inst_i,
    output logic              reg1_read_o,
    output logic              reg2_read_o,
    output logic [4:0]        reg1_addr_o,
    output logic [4:0]        reg2_addr_o,
    input  logic [DATA_W-1:0] reg1_data_i,
    input  logic [DATA_W-1:0] reg2_data_i,
    input  logic              ex_wreg_i,
    input  logic [4:0]        ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              ex_is_load_i,
    input  logic              mem_wreg_i,
    input  logic [4:0]        mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              flush_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        aluop_o,
    output logic [2:0]        alusel_o,
    output logic [DATA_W-1:0] reg1_o,
    output logic [DATA_W-1:0] reg2_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [PC_W-1:0]   pc_o,
    output logic              invalid_o
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [7:0] ALU_NOP = 8'h00;
    localparam logic [7:0] ALU_AND = 8'h24;
    localparam logic [7:0] ALU_OR  = 8'h25;
    localparam logic [7:0] ALU_XOR = 8'h26;
    localparam logic [7:0] ALU_NOR = 8'h27;
    localparam logic [7:0] ALU_SLL = 8'h7C;
    localparam logic [7:0] ALU_SRL = 8'h02;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;

    assign opcode = inst_i[31:26];
    assign rs     = inst_i[25:21];
    assign rt     = inst_i[20:16];
    assign rd     = inst_i[15:11];
    assign shamt  = inst_i[10:6];
    assign funct  = inst_i[5:0];
    assign imm    = inst_i[15:0];

    logic [7:0]        dec_aluop;
    logic [2:0]        dec_alusel;
    logic              dec_read1;
    logic              dec_read2;
    logic [4:0]        dec_wd;
    logic              dec_wen;
    logic              dec_wreg;
    logic              dec_invalid;
    logic [DATA_W-1:0] dec_imm1;
    logic [DATA_W-1:0] dec_imm2;

    always_comb begin
        dec_aluop   = ALU_NOP;
        dec_alusel  = SEL_NOP;
        dec_read1   = 1'b0;
        dec_read2   = 1'b0;
        dec_wd      = 5'd0;
        dec_wen     = 1'b0;
        dec_invalid = 1'b1;
        dec_imm1    = '0;
        dec_imm2    = '0;
        case (opcode)
            OP_ORI, OP_ANDI, OP_XORI, OP_LUI: begin
                dec_read1   = 1'b1;
                dec_wd      = rt;
                dec_wen     = 1'b1;
                dec_alusel  = SEL_LOGIC;
                dec_invalid = 1'b0;
                dec_imm2    = DATA_W'(imm);
                case (opcode)
                    OP_ANDI: dec_aluop = ALU_AND;
                    OP_XORI: dec_aluop = ALU_XOR;
                    OP_LUI: begin
                        dec_aluop = ALU_OR;
                        dec_imm2  = DATA_W'({imm, 16'h0000});
                    end
                    default: dec_aluop = ALU_OR;
                endcase
            end
            OP_SPECIAL: begin
                if ((shamt == 5'd0) &&
                    ((funct == FN_AND) || (funct == FN_OR) ||
                     (funct == FN_XOR) || (funct == FN_NOR))) begin
                    dec_read1   = 1'b1;
                    dec_read2   = 1'b1;
                    dec_wd      = rd;
                    dec_wen     = 1'b1;
                    dec_alusel  = SEL_LOGIC;
                    dec_invalid = 1'b0;
                    case (funct)
                        FN_AND:  dec_aluop = ALU_AND;
                        FN_OR:   dec_aluop = ALU_OR;
                        FN_XOR:  dec_aluop = ALU_XOR;
                        default: dec_aluop = ALU_NOR;
                    endcase
                end else if ((rs == 5'd0) && ((funct == FN_SLL) || (funct == FN_SRL))) begin
                    // Shifts take the shift amount as operand 1 and the shifted value from rt.
                    dec_read2   = 1'b1;
                    dec_imm1    = DATA_W'(shamt);
                    dec_wd      = rd;
                    dec_wen     = 1'b1;
                    dec_alusel  = SEL_SHIFT;
                    dec_invalid = 1'b0;
                    dec_aluop   = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
                end
            end
            default: ;
        endcase
    end

    assign dec_wreg    = dec_wen && (dec_wd != 5'd0);
    assign reg1_read_o = dec_read1;
    assign reg2_read_o = dec_read2;
    assign reg1_addr_o = rs;
    assign reg2_addr_o = rt;

    function automatic logic [DATA_W-1:0] resolve_operand(
        input logic [4:0]        addr,
        input logic [DATA_W-1:0] rf_data,
        input logic              ex_wreg,
        input logic [4:0]        ex_wd,
        input logic [DATA_W-1:0] ex_wdata,
        input logic              ex_load,
        input logic              mem_wreg,
        input logic [4:0]        mem_wd,
        input logic [DATA_W-1:0] mem_wdata
    );
        logic [DATA_W-1:0] result;
        result = rf_data;
        if (addr == 5'd0)
            result = '0;
        else if (FWD_EN && ex_wreg && (ex_wd == addr) && !ex_load)
            result = ex_wdata;
        else if (FWD_EN && mem_wreg && (mem_wd == addr))
            result = mem_wdata;
        return result;
    endfunction

    // Without forwarding any pending EX/MEM write to a source register must stall.
    function automatic logic source_hazard(
        input logic       rd_en,
        input logic [4:0] addr,
        input logic       ex_wreg,
        input logic [4:0] ex_wd,
        input logic       ex_load,
        input logic       mem_wreg,
        input logic [4:0] mem_wd
    );
        logic ex_hit;
        logic mem_hit;
        ex_hit  = ex_wreg && (ex_wd == addr);
        mem_hit = mem_wreg && (mem_wd == addr);
        if (!rd_en || (addr == 5'd0))
            return 1'b0;
        return (ex_hit && ex_load) || (!FWD_EN && (ex_hit || mem_hit));
    endfunction

    logic [DATA_W-1:0] op1_data;
    logic [DATA_W-1:0] op2_data;
    logic              hazard;
    logic              accept;

    always_comb begin
        op1_data = dec_imm1;
        op2_data = dec_imm2;
        if (dec_read1)
            op1_data = resolve_operand(rs, reg1_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                                       ex_is_load_i, mem_wreg_i, mem_wd_i, mem_wdata_i);
        if (dec_read2)
            op2_data = resolve_operand(rt, reg2_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                                       ex_is_load_i, mem_wreg_i, mem_wd_i, mem_wdata_i);
    end

    assign hazard = source_hazard(dec_read1, rs, ex_wreg_i, ex_wd_i, ex_is_load_i,
                                  mem_wreg_i, mem_wd_i) ||
                    source_hazard(dec_read2, rt, ex_wreg_i, ex_wd_i, ex_is_load_i,
                                  mem_wreg_i, mem_wd_i);

    logic              out_valid_q, out_valid_d;
    logic [7:0]        aluop_q, aluop_d;
    logic [2:0]        alusel_q, alusel_d;
    logic [DATA_W-1:0] reg1_q, reg1_d;
    logic [DATA_W-1:0] reg2_q, reg2_d;
    logic [4:0]        wd_q, wd_d;
    logic              wreg_q, wreg_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              invalid_q, invalid_d;

    assign in_ready = !flush_i && !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Fields only load on accept, so they stay frozen while a result waits for EX.
    always_comb begin
        out_valid_d = out_valid_q;
        aluop_d     = aluop_q;
        alusel_d    = alusel_q;
        reg1_d      = reg1_q;
        reg2_d      = reg2_q;
        wd_d        = wd_q;
        wreg_d      = wreg_q;
        pc_d        = pc_q;
        invalid_d   = invalid_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            aluop_d     = dec_aluop;
            alusel_d    = dec_alusel;
            reg1_d      = op1_data;
            reg2_d      = op2_data;
            wd_d        = dec_wd;
            wreg_d      = dec_wreg;
            pc_d        = pc_i;
            invalid_d   = dec_invalid;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            aluop_q     <= '0;
            alusel_q    <= '0;
            reg1_q      <= '0;
            reg2_q      <= '0;
            wd_q        <= '0;
            wreg_q      <= 1'b0;
            pc_q        <= '0;
            invalid_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            aluop_q     <= aluop_d;
            alusel_q    <= alusel_d;
            reg1_q      <= reg1_d;
            reg2_q      <= reg2_d;
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            pc_q        <= pc_d;
            invalid_q   <= invalid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign aluop_o   = aluop_q;
    assign alusel_o  = alusel_q;
    assign reg1_o    = reg1_q;
    assign reg2_o    = reg2_q;
    assign wd_o      = wd_q;
    assign wreg_o    = wreg_q;
    assign pc_o      = pc_q;
    assign invalid_o = invalid_q;

endmodule

// File: tb/tb_id_pipe.sv
// Bench for id_pipe: directed scenarios plus random traffic checked against a
// behavioural model of the decode table, forwarding priority and handshake.
module tb_id_pipe;

    localparam int DATA_W = 32;
    localparam int PC_W   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   pc_i;
    logic [31:0]       inst_i;
    logic              reg1_read_o, reg2_read_o;
    logic [4:0]        reg1_addr_o, reg2_addr_o;
    logic [DATA_W-1:0] reg1_data_i, reg2_data_i;
    logic              ex_wreg_i;
    logic [4:0]        ex_wd_i;
    logic [DATA_W-1:0] ex_wdata_i;
    logic              ex_is_load_i;
    logic              mem_wreg_i;
    logic [4:0]        mem_wd_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic              flush_i;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        aluop_o;
    logic [2:0]        alusel_o;
    logic [DATA_W-1:0] reg1_o, reg2_o;
    logic [4:0]        wd_o;
    logic              wreg_o;
    logic [PC_W-1:0]   pc_o;
    logic              invalid_o;

    id_pipe #(.DATA_W(DATA_W), .PC_W(PC_W), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .inst_i(inst_i),
        .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
        .ex_is_load_i(ex_is_load_i),
        .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
        .flush_i(flush_i), .out_valid(out_valid), .out_ready(out_ready),
        .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o), .invalid_o(invalid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] pc;
        logic        invalid;
    } out_state_t;

    typedef struct {
        logic        invalid;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic        read1;
        logic        read2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] fixed1;
        logic [31:0] fixed2;
    } decoded_t;

    int          compare_count  = 0;
    int          mismatch_count = 0;
    logic [31:0] reg_file [32];
    out_state_t  model;
    logic        seen_ready;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compare_count++;
        if (got !== exp) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // The logic funct codes 0x24..0x27 coincide numerically with their aluop codes.
    function automatic decoded_t refDecode(input logic [31:0] w);
        decoded_t d;
        logic [5:0] op, fn;
        op = w[31:26];
        fn = w[5:0];
        d = '{invalid: 1'b1, aluop: 8'h00, alusel: 3'd0, read1: 1'b0, read2: 1'b0,
              wd: 5'd0, wreg: 1'b0, fixed1: 32'd0, fixed2: 32'd0};
        if (op >= 6'd12 && op <= 6'd15) begin
            d.invalid = 1'b0;
            d.alusel  = 3'd1;
            d.read1   = 1'b1;
            d.wd      = w[20:16];
            d.fixed2  = 32'(w[15:0]);
            if (op == 6'd12)      d.aluop = 8'h24;
            else if (op == 6'd14) d.aluop = 8'h26;
            else                  d.aluop = 8'h25;
            if (op == 6'd15) d.fixed2 = 32'(w[15:0]) * 32'd65536;
        end else if (op == 6'd0 && w[10:6] == 5'd0 && fn >= 6'h24 && fn <= 6'h27) begin
            d.invalid = 1'b0;
            d.alusel  = 3'd1;
            d.aluop   = 8'(fn);
            d.read1   = 1'b1;
            d.read2   = 1'b1;
            d.wd      = w[15:11];
        end else if (op == 6'd0 && w[25:21] == 5'd0 && (fn == 6'd0 || fn == 6'd2)) begin
            d.invalid = 1'b0;
            d.alusel  = 3'd2;
            d.aluop   = (fn == 6'd0) ? 8'h7C : 8'h02;
            d.read2   = 1'b1;
            d.fixed1  = 32'(w[10:6]);
            d.wd      = w[15:11];
        end
        d.wreg = !d.invalid && (d.wd != 5'd0);
        return d;
    endfunction

    function automatic logic [31:0] refOperand(input logic [4:0] addr);
        if (addr == 5'd0) return 32'd0;
        if (ex_wreg_i && ex_wd_i == addr && !ex_is_load_i) return ex_wdata_i;
        if (mem_wreg_i && mem_wd_i == addr) return mem_wdata_i;
        return reg_file[addr];
    endfunction

    function automatic logic refLoadUse(input decoded_t d, input logic [31:0] w);
        logic hit;
        hit = 1'b0;
        if (ex_wreg_i && ex_is_load_i && ex_wd_i != 5'd0) begin
            if (d.read1 && w[25:21] == ex_wd_i) hit = 1'b1;
            if (d.read2 && w[20:16] == ex_wd_i) hit = 1'b1;
        end
        return hit;
    endfunction

    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                                 input logic flush, input logic ready);
        in_valid    = v;
        inst_i      = inst;
        pc_i        = pc;
        flush_i     = flush;
        out_ready   = ready;
        reg1_data_i = reg_file[inst[25:21]];
        reg2_data_i = reg_file[inst[20:16]];
    endtask

    task automatic applyForward(input logic exw, input logic [4:0] exd, input logic [31:0] exv,
                                input logic exl, input logic mw, input logic [4:0] md,
                                input logic [31:0] mv);
        ex_wreg_i    = exw;
        ex_wd_i      = exd;
        ex_wdata_i   = exv;
        ex_is_load_i = exl;
        mem_wreg_i   = mw;
        mem_wd_i     = md;
        mem_wdata_i  = mv;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, ".out_valid"}, out_valid, model.valid);
        checkOutput({tag, ".aluop"},     aluop_o,   model.aluop);
        checkOutput({tag, ".alusel"},    alusel_o,  model.alusel);
        checkOutput({tag, ".reg1"},      reg1_o,    model.reg1);
        checkOutput({tag, ".reg2"},      reg2_o,    model.reg2);
        checkOutput({tag, ".wd"},        wd_o,      model.wd);
        checkOutput({tag, ".wreg"},      wreg_o,    model.wreg);
        checkOutput({tag, ".pc"},        pc_o,      model.pc);
        checkOutput({tag, ".invalid"},   invalid_o, model.invalid);
    endtask

    // Called just after a falling edge with inputs already driven; ends at the next falling edge.
    task automatic runCycle(input string tag);
        decoded_t d;
        logic     exp_ready;
        #1;
        d = refDecode(inst_i);
        exp_ready = !flush_i && !refLoadUse(d, inst_i) && (!model.valid || out_ready);
        seen_ready = in_ready;
        checkOutput({tag, ".in_ready"},  in_ready,    exp_ready);
        checkOutput({tag, ".rd1_en"},    reg1_read_o, d.read1);
        checkOutput({tag, ".rd2_en"},    reg2_read_o, d.read2);
        checkOutput({tag, ".rd_addrs"},  {reg1_addr_o, reg2_addr_o}, {inst_i[25:21], inst_i[20:16]});
        if (flush_i) begin
            model.valid = 1'b0;
        end else if (in_valid && exp_ready) begin
            model.valid   = 1'b1;
            model.aluop   = d.aluop;
            model.alusel  = d.alusel;
            model.reg1    = d.read1 ? refOperand(inst_i[25:21]) : d.fixed1;
            model.reg2    = d.read2 ? refOperand(inst_i[20:16]) : d.fixed2;
            model.wd      = d.wd;
            model.wreg    = d.wreg;
            model.pc      = pc_i;
            model.invalid = d.invalid;
        end else if (out_ready) begin
            model.valid = 1'b0;
        end
        @(posedge clk);
        #1;
        checkModel(tag);
        @(negedge clk);
    endtask

    function automatic logic [31:0] randInst();
        logic [4:0] a, b, c;
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        c = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 7))
            0: return {6'b001101, a, b, 16'($urandom)};
            1: return {6'b001100, a, b, 16'($urandom)};
            2: return {6'b001110, a, b, 16'($urandom)};
            3: return {6'b001111, a, b, 16'($urandom)};
            4: return {6'b000000, a, b, c, 5'd0, 6'(6'h24 + $urandom_range(0, 3))};
            5: return {6'b000000, 5'd0, b, c, 5'($urandom), ($urandom_range(0, 1) == 0) ? 6'd0 : 6'd2};
            6: return {6'b000000, a, b, c, 5'($urandom_range(1, 31)), 6'h25};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] inst_r;
        logic [31:0] pc_r;
        logic        hold;

        model = '{valid: 1'b0, aluop: 8'h0, alusel: 3'h0, reg1: 32'h0, reg2: 32'h0,
                  wd: 5'h0, wreg: 1'b0, pc: 32'h0, invalid: 1'b0};
        for (int i = 0; i < 32; i++) reg_file[i] = $urandom;
        reg_file[1] = 32'h0000_1234;
        reg_file[2] = 32'h0000_5678;
        applyForward(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

        rst = 1'b0;
        #1;
        checkModel("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] ORI decode");
        applyStimulus(1'b1, 32'h3422_00FF, 32'h100, 1'b0, 1'b1);
        runCycle("ori");
        checkOutput("ori.aluop_const", aluop_o, 8'h25);
        checkOutput("ori.reg1_const",  reg1_o,  32'h1234);
        checkOutput("ori.reg2_const",  reg2_o,  32'hFF);
        checkOutput("ori.wd_const",    {wd_o, wreg_o}, {5'd2, 1'b1});

        $display("[TB] forwarding priority");
        applyForward(1'b1, 5'd1, 32'hA, 1'b0, 1'b1, 5'd2, 32'hB);
        applyStimulus(1'b1, 32'h0022_1825, 32'h104, 1'b0, 1'b1);
        runCycle("fwd");
        checkOutput("fwd.reg1_ex",  reg1_o, 32'hA);
        checkOutput("fwd.reg2_mem", reg2_o, 32'hB);
        applyForward(1'b1, 5'd1, 32'hA, 1'b0, 1'b1, 5'd1, 32'hB);
        applyStimulus(1'b1, 32'h0022_1825, 32'h108, 1'b0, 1'b1);
        runCycle("fwd_both");
        checkOutput("fwd_both.ex_wins", reg1_o, 32'hA);

        $display("[TB] load-use stall");
        applyForward(1'b1, 5'd1, 32'hDEAD, 1'b1, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, {6'b001100, 5'd1, 5'd2, 16'h000F}, 32'h10C, 1'b0, 1'b1);
        runCycle("lu");
        checkOutput("lu.ready_low",  seen_ready, 1'b0);
        checkOutput("lu.bubble",     out_valid,  1'b0);
        applyForward(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
        applyStimulus(1'b1, {6'b001100, 5'd1, 5'd2, 16'h000F}, 32'h10C, 1'b0, 1'b1);
        runCycle("lu_release");
        checkOutput("lu_release.reg1", reg1_o, 32'h1234);

        $display("[TB] backpressure");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, {6'b001110, 5'd2, 5'd3, 16'h00F0}, 32'h110, 1'b0, 1'b0);
            runCycle("bp");
            checkOutput("bp.ready_low", seen_ready, 1'b0);
            checkOutput("bp.pc_held",   pc_o, 32'h10C);
        end
        applyStimulus(1'b1, {6'b001110, 5'd2, 5'd3, 16'h00F0}, 32'h110, 1'b0, 1'b1);
        runCycle("bp_release");
        checkOutput("bp_release.pc", pc_o, 32'h110);

        $display("[TB] illegal and NOP words");
        applyStimulus(1'b1, 32'hFC00_0000, 32'h114, 1'b0, 1'b1);
        runCycle("illegal");
        checkOutput("illegal.flags", {invalid_o, aluop_o, wreg_o}, {1'b1, 8'h00, 1'b0});
        applyStimulus(1'b1, 32'h0000_0000, 32'h118, 1'b0, 1'b1);
        runCycle("nop");
        checkOutput("nop.flags", {invalid_o, wreg_o}, {1'b0, 1'b0});

        $display("[TB] flush");
        applyStimulus(1'b1, 32'h3422_0001, 32'h11C, 1'b1, 1'b0);
        runCycle("flush");
        checkOutput("flush.ready_low", seen_ready, 1'b0);
        checkOutput("flush.valid_low", out_valid,  1'b0);
        applyStimulus(1'b1, 32'h3422_0001, 32'h11C, 1'b0, 1'b0);
        runCycle("post_flush");
        checkOutput("post_flush.pc", {out_valid, pc_o}, {1'b1, 32'h11C});

        $display("[TB] reset during stall");
        applyStimulus(1'b1, 32'h3422_0002, 32'h120, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        model = '{valid: 1'b0, aluop: 8'h0, alusel: 3'h0, reg1: 32'h0, reg2: 32'h0,
                  wd: 5'h0, wreg: 1'b0, pc: 32'h0, invalid: 1'b0};
        checkModel("async_rst");
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h3422_0002, 32'h120, 1'b0, 1'b0);
        runCycle("after_rst");

        $display("[TB] random traffic");
        hold   = 1'b0;
        inst_r = 32'd0;
        pc_r   = 32'h200;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                inst_r = randInst();
                pc_r   = pc_r + 32'd4;
            end
            for (int r = 0; r < 32; r++) if ($urandom_range(0, 7) == 0) reg_file[r] = $urandom;
            applyForward($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom,
                         $urandom_range(0, 3) == 0,
                         $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom);
            applyStimulus($urandom_range(0, 4) != 0, inst_r, pc_r,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
            runCycle("rand");
            hold = in_valid && !seen_ready && !flush_i;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
